slave_port_burst: RTL

- Next-generation bit-serial bus slave with a parametrised local memory window and a base-address decode.
- Supports multi-word burst reads and writes, with an error response for out-of-window addresses.
- Sits on the serial system bus behind the master port and arbiter.
- Command header: address, then burst length, both serial MSB-first, followed by write data or read return.

---
 rtl/slave_port_burst.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/slave_port_burst.sv
// Bit-serial bus slave with a local memory window and base-address decode.
// Header (address, burst length) arrives MSB-first on wr_bus; write bursts
// follow on wr_bus, read bursts return on rd_bus. Addresses outside the
// window park the port in ERR until the master releases master_valid.
module slave_port_burst #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4,
   parameter int MEM_DEPTH  = 64,
   parameter int BASE_ADDR  = 0
) (
   input  logic clk,
   input  logic rstn,
   input  logic mode,
   input  logic wr_bus,
   input  logic master_valid,
   input  logic master_ready,
   output logic rd_bus,
   output logic slave_ready,
   output logic slave_valid,
   output logic slave_err
);
   localparam int IW   = $clog2(MEM_DEPTH);
   localparam int MAXW = (ADDR_WIDTH > LEN_WIDTH)
                         ? ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH)
                         : ((LEN_WIDTH > DATA_WIDTH) ? LEN_WIDTH : DATA_WIDTH);
   localparam int BW   = $clog2(MAXW + 1);
   localparam int WW   = LEN_WIDTH + 1;
   // One extra bit so a window touching the top of the address space still compares correctly
   localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(BASE_ADDR + MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, ADDR, LEN, WDATA, RLOAD, RSEND, ERR} state_t;

   state_t                  state, state_nx;
   logic                    mode_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LEN_WIDTH-1:0]    len_q, len_nx;
   logic [DATA_WIDTH-1:0]   sh, sh_nx;
   logic [BW-1:0]           bcnt;
   logic [WW-1:0]           wleft;
   logic [IW-1:0]           idx, idx_dec;
   logic                    addr_last, len_last, data_last, in_win, last_word, mem_we;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   assign addr_last = (bcnt == BW'(ADDR_WIDTH - 1));
   assign len_last  = (bcnt == BW'(LEN_WIDTH - 1));
   assign data_last = (bcnt == BW'(DATA_WIDTH - 1));
   assign last_word = (wleft == WW'(1));
   assign len_nx    = (len_q << 1) | LEN_WIDTH'(wr_bus);
   assign sh_nx     = (sh << 1) | DATA_WIDTH'(wr_bus);
   assign in_win    = ({1'b0, addr_q} >= WIN_LO) && ({1'b0, addr_q} < WIN_HI);
   assign idx_dec   = IW'(addr_q - ADDR_WIDTH'(BASE_ADDR));
   assign mem_we    = rstn && (state == WDATA) && master_valid && data_last;

   // Outputs decode from registered state; forced low while reset is asserted
   assign slave_ready = rstn && ((state == ADDR) || (state == LEN) || (state == WDATA));
   assign slave_valid = rstn && (state == RSEND);
   assign slave_err   = rstn && (state == ERR);
   assign rd_bus      = rstn && (state == RSEND) && sh[DATA_WIDTH-1];

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state: header, decode, burst sequencing, abort and error release
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (master_valid) state_nx = ADDR;
         ADDR:  if (!master_valid) state_nx = IDLE;
                else if (addr_last) state_nx = LEN;
         LEN:   if (!master_valid) state_nx = IDLE;
                else if (len_last) state_nx = !in_win ? ERR : (mode_q ? WDATA : RLOAD);
         WDATA: if (!master_valid) state_nx = IDLE;
                else if (data_last && last_word) state_nx = IDLE;
         RLOAD: state_nx = RSEND;
         RSEND: if (master_ready && data_last) state_nx = last_word ? IDLE : RLOAD;
         ERR:   if (!master_valid) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: shift registers, bit/word counters and the memory index
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mode_q <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         sh     <= '0;
         bcnt   <= '0;
         wleft  <= '0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               bcnt <= '0;
               if (master_valid) mode_q <= mode;
            end
            ADDR: if (master_valid) begin
               addr_q <= (addr_q << 1) | ADDR_WIDTH'(wr_bus);
               bcnt   <= addr_last ? '0 : bcnt + BW'(1);
            end
            LEN: if (master_valid) begin
               len_q <= len_nx;
               bcnt  <= len_last ? '0 : bcnt + BW'(1);
               if (len_last) begin
                  idx   <= idx_dec;
                  wleft <= WW'(len_nx) + WW'(1);
               end
            end
            WDATA: if (master_valid) begin
               sh <= sh_nx;
               if (data_last) begin
                  bcnt  <= '0;
                  idx   <= idx + IW'(1);
                  wleft <= wleft - WW'(1);
               end else begin
                  bcnt <= bcnt + BW'(1);
               end
            end
            RLOAD: begin
               sh   <= mem[idx];
               bcnt <= '0;
            end
            RSEND: if (master_ready) begin
               sh <= sh << 1;
               if (data_last) begin
                  bcnt  <= '0;
                  idx   <= idx + IW'(1);
                  wleft <= wleft - WW'(1);
               end else begin
                  bcnt <= bcnt + BW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Word commit on the edge that accepts the final data bit; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= sh_nx;
   end

endmodule
